// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder controller: FSM encodings and default width.
package serial_adder_pkg;

  localparam int SA_DEFAULT_N = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_fadder.sv
// One-bit full adder shared by the serial adder datapath.
module FADDER (
  output logic s,
  output logic c,
  input  logic x,
  input  logic y,
  input  logic z
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: latches operands, feeds FADDER LSB first, and
// reports {cout,sum} through a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// SHIFT | one bit pair per cycle through FADDER, N cycles
// DONE  | one-cycle done pulse, then back to IDLE
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int N = SA_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_sh_q, a_sh_d;
  logic [N-1:0]  b_sh_q, b_sh_d;
  logic [N-1:0]  sum_sh_q, sum_sh_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fa_s, fa_c;

  FADDER u_fadder (
    .s (fa_s),
    .c (fa_c),
    .x (a_sh_q[0]),
    .y (b_sh_q[0]),
    .z (carry_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // Datapath only moves on accept (load) and during SHIFT; result holds otherwise.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    if (state_q == IDLE && start) begin
      a_sh_d   = a;
      b_sh_d   = b;
      sum_sh_d = '0;
      carry_d  = cin;
      cnt_d    = '0;
    end else if (state_q == SHIFT) begin
      a_sh_d   = {1'b0, a_sh_q[N-1:1]};
      b_sh_d   = {1'b0, b_sh_q[N-1:1]};
      sum_sh_d = {fa_s, sum_sh_q[N-1:1]};
      carry_d  = fa_c;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sum  = sum_sh_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of serial_adder_ctrl against an arithmetic model.
module tb_serial_adder_ctrl;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  int checks;
  int failures;

  serial_adder_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge with the DUT in IDLE. Returns at the first IDLE negedge after done.
  // inj: SHIFT cycle at which a stray start with operands 1+1 is pulsed (0 = none).
  // noise: scramble inputs and start while SHIFT runs.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc,
                        input int inj, input bit noise, input string tag);
    logic [N:0] exp;
    exp   = {1'b0, ta} + {1'b0, tb} + {{N{1'b0}}, tc};
    a     = ta;
    b     = tb;
    cin   = tc;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == inj) begin
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
      end else if (noise && k <= N) begin
        a     = N'($urandom);
        b     = N'($urandom);
        cin   = 1'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      if (k <= N) begin
        chk({tag, " busy_phase"}, {30'd0, busy, done}, 32'h2);
      end else begin
        chk({tag, " done_pulse"}, {30'd0, busy, done}, 32'h1);
        chk({tag, " result"}, {23'd0, cout, sum}, {23'd0, exp});
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, " idle_after"}, {30'd0, busy, done}, 32'h0);
    chk({tag, " hold_result"}, {23'd0, cout, sum}, {23'd0, exp});
  endtask

  initial begin
    int         prev;
    int         pulses;
    int         gap;
    logic [N:0] ref_sum;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy_done", {30'd0, busy, done}, 32'h0);
    chk("reset_result", {23'd0, cout, sum}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h35, 8'h4A, 1'b0, 0, 1'b0, "add_35_4a");
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, "add_ff_01");
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b0, "add_cin_only");
    run_op(8'hAA, 8'h55, 1'b0, 3, 1'b0, "ignored_start");

    // Asynchronous reset in the middle of SHIFT
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    start = 1'b0;
    chk("pre_reset_busy", {31'd0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", {30'd0, busy, done}, 32'h0);
    chk("async_reset_result", {23'd0, cout, sum}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {30'd0, busy, done}, 32'h0);
    run_op(8'h10, 8'h20, 1'b0, 0, 1'b0, "after_reset");

    // start held high: done every N+2 cycles
    a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
    prev   = -1;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (busy && done) chk("busy_done_exclusive", 32'h1, 32'h0);
      if (done) begin
        pulses++;
        chk("held_result", {23'd0, cout, sum}, 32'h101);
        if (prev >= 0) chk("held_period", i - prev, N + 2);
        prev = i;
      end else if (!busy && prev >= 0) begin
        chk("held_idle_stable", {23'd0, cout, sum}, 32'h101);
      end
    end
    start = 1'b0;
    chk("held_pulse_count", (pulses >= 3) ? 32'h1 : 32'h0, 32'h1);
    repeat (N + 3) @(negedge clk);
    chk("held_drained", {30'd0, busy, done}, 32'h0);

    for (int v = 0; v < 500; v++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic         rc;
      ra  = N'($urandom);
      rb  = N'($urandom);
      rc  = 1'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
      run_op(ra, rb, rc, 0, 1'b1, "random");
      chk("random_model", {23'd0, cout, sum}, {23'd0, ref_sum});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
